seg_scan_ctrl: RTL and testbench

Time-multiplexed seven-segment display controller for the packed-BCD words produced by the code-conversion datapath. It accepts a new BCD word through a valid/ready handshake and holds it in a one-entry pending buffer. It transfers the word to the display register only at frame boundaries, so a digit never changes mid-frame. It then scans the digits one at a time through a guard/drive state machine, with anti-ghosting blanking between digits.

---
 rtl/seg_pkg.sv | 24 ++
 rtl/bcd_seg_dec.sv | 27 ++
 rtl/seg_scan_ctrl.sv | 155 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared FSM state type and active-low seven-segment glyphs
package seg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GUARD = 2'd1,
      ST_DRIVE = 2'd2
   } seg_state_t;

   // Active-low glyphs, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_seg_dec.sv
// rtl/bcd_seg_dec.sv - combinational BCD nibble to active-low segment decoder
module bcd_seg_dec
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);

   // Non-BCD codes show a dash so corrupt data is visible rather than silent
   always_comb begin
      seg_n = SEG_DASH;
      case (nibble)
         4'd0:    seg_n = SEG_0;
         4'd1:    seg_n = SEG_1;
         4'd2:    seg_n = SEG_2;
         4'd3:    seg_n = SEG_3;
         4'd4:    seg_n = SEG_4;
         4'd5:    seg_n = SEG_5;
         4'd6:    seg_n = SEG_6;
         4'd7:    seg_n = SEG_7;
         4'd8:    seg_n = SEG_8;
         4'd9:    seg_n = SEG_9;
         default: seg_n = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed seven-segment scanner with frame-aligned word updates
// Optional build macro: SEG_LEADING_ZERO_BLANK_EN (suppresses leading zero digits).
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int N_DIGITS     = 2,
   parameter int DRIVE_CYCLES = 1000,
   parameter int GUARD_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  bcd_valid,
   input  logic [4*N_DIGITS-1:0] bcd_data,
   output logic                  bcd_ready,
   output logic [N_DIGITS-1:0]   an_n,
   output logic [6:0]            seg_n,
   output logic                  frame_start
);

   localparam int IDX_W   = $clog2(N_DIGITS);
   localparam int CNT_MAX = (DRIVE_CYCLES > GUARD_CYCLES) ? DRIVE_CYCLES : GUARD_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRIVE_LOAD = CNT_W'(DRIVE_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

   seg_state_t            state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [IDX_W-1:0]      idx, idx_nxt;
   logic [4*N_DIGITS-1:0] pending, pending_nxt;
   logic [4*N_DIGITS-1:0] display, display_nxt;
   logic                  pending_full, pending_full_nxt;

   logic                  accept;
   logic                  cnt_done;
   logic                  frame_end;
   logic                  load_display;

   logic [3:0]            nibble_sel;
   logic [6:0]            dec_seg;
   logic [N_DIGITS-1:0]   lead_blank;
   logic [N_DIGITS-1:0]   an_nxt;
   logic [6:0]            seg_nxt;
   logic                  fs_nxt;

   assign accept       = bcd_valid & bcd_ready;
   assign cnt_done     = (cnt == '0);
   assign frame_end    = (state == ST_DRIVE) & cnt_done & (idx == IDX_LAST);
   // A word only reaches the display before the first frame or between frames
   assign load_display = ((state == ST_IDLE) | frame_end) & pending_full;

   assign display_nxt      = load_display ? pending : display;
   assign pending_nxt      = accept ? bcd_data : pending;
   assign pending_full_nxt = accept ? 1'b1 : (load_display ? 1'b0 : pending_full);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         idx          <= '0;
         pending      <= '0;
         pending_full <= 1'b0;
         display      <= '0;
         bcd_ready    <= 1'b1;
         an_n         <= '1;
         seg_n        <= SEG_BLANK;
         frame_start  <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         idx          <= idx_nxt;
         pending      <= pending_nxt;
         pending_full <= pending_full_nxt;
         display      <= display_nxt;
         bcd_ready    <= ~pending_full_nxt;
         an_n         <= an_nxt;
         seg_n        <= seg_nxt;
         frame_start  <= fs_nxt;
      end
   end

   // One down-counter serves both timed states; it reloads on every state entry
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      case (state)
         ST_IDLE: begin
            if (pending_full) begin
               state_nxt = ST_GUARD;
               cnt_nxt   = GUARD_LOAD;
               idx_nxt   = '0;
            end
         end
         ST_GUARD: begin
            if (cnt_done) begin
               state_nxt = ST_DRIVE;
               cnt_nxt   = DRIVE_LOAD;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         ST_DRIVE: begin
            if (cnt_done) begin
               state_nxt = ST_GUARD;
               cnt_nxt   = GUARD_LOAD;
               idx_nxt   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
         end
      endcase
   end

   assign nibble_sel = display_nxt[{idx_nxt, 2'b00} +: 4];

   bcd_seg_dec u_dec (
      .nibble (nibble_sel),
      .seg_n  (dec_seg)
   );

`ifdef SEG_LEADING_ZERO_BLANK_EN
   logic higher_zero;

   // Digit i is blanked when it and every digit above it are zero; digit 0 never is
   always_comb begin
      lead_blank  = '0;
      higher_zero = 1'b1;
      for (int i = N_DIGITS - 1; i >= 1; i--) begin
         higher_zero   = higher_zero & (display_nxt[i*4 +: 4] == 4'd0);
         lead_blank[i] = higher_zero;
      end
   end
`else
   assign lead_blank = '0;
`endif

   // Outputs are computed from the next state so they register alongside it
   always_comb begin
      an_nxt  = '1;
      seg_nxt = SEG_BLANK;
      fs_nxt  = (state_nxt == ST_GUARD) && (state != ST_GUARD) && (idx_nxt == '0);
      if ((state_nxt == ST_DRIVE) && !lead_blank[idx_nxt]) begin
         an_nxt[idx_nxt] = 1'b0;
         seg_nxt         = dec_seg;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl against a frame-arithmetic model
module tb_seg_scan_ctrl;

   localparam int N     = 2;
   localparam int DRV   = 4;
   localparam int GRD   = 2;
   localparam int SLOT  = GRD + DRV;
   localparam int FRAME = N * SLOT;

   localparam logic [6:0] GLYPH [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                         7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   typedef struct packed {
      logic [N-1:0] an;
      logic [6:0]   seg;
      logic         fs;
      logic         rdy;
   } exp_t;

   logic           clk;
   logic           rst_n;
   logic           bcd_valid;
   logic [4*N-1:0] bcd_data;
   logic           bcd_ready;
   logic [N-1:0]   an_n;
   logic [6:0]     seg_n;
   logic           frame_start;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   exp_t exp_q[$];

   bit             m_started;
   bit             m_pend_full;
   logic [4*N-1:0] m_pend;
   logic [4*N-1:0] m_disp;
   int             m_t;

   seg_scan_ctrl #(
      .N_DIGITS     (N),
      .DRIVE_CYCLES (DRV),
      .GUARD_CYCLES (GRD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bcd_valid   (bcd_valid),
      .bcd_data    (bcd_data),
      .bcd_ready   (bcd_ready),
      .an_n        (an_n),
      .seg_n       (seg_n),
      .frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] glyph(input logic [3:0] nib);
      return (nib < 4'd10) ? GLYPH[nib] : 7'h3F;
   endfunction

   function automatic bit blanked(input logic [4*N-1:0] w, input int d);
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (d == 0) return 1'b0;
      for (int i = d; i < N; i++)
         if (w[i*4 +: 4] != 4'd0) return 1'b0;
      return 1'b1;
`else
      return (d < 0);
`endif
   endfunction

   // Reference: position within the frame decides everything
   task automatic model_step();
      exp_t e;
      bit   acc;
      int   slot;
      int   off;
      cyc++;
      if (!rst_n) begin
         m_started   = 1'b0;
         m_pend_full = 1'b0;
         m_pend      = '0;
         m_disp      = '0;
         m_t         = 0;
      end else begin
         acc = bcd_valid && !m_pend_full;
         if (!m_started) begin
            if (m_pend_full) begin
               m_disp      = m_pend;
               m_pend_full = 1'b0;
               m_started   = 1'b1;
               m_t         = 0;
            end
         end else begin
            m_t++;
            if (m_t == FRAME) begin
               m_t = 0;
               if (m_pend_full) begin
                  m_disp      = m_pend;
                  m_pend_full = 1'b0;
               end
            end
         end
         if (acc) begin
            m_pend_full = 1'b1;
            m_pend      = bcd_data;
         end
      end
      e.an  = '1;
      e.seg = 7'h7F;
      e.fs  = 1'b0;
      e.rdy = !m_pend_full;
      if (m_started) begin
         slot = m_t / SLOT;
         off  = m_t % SLOT;
         e.fs = (m_t == 0);
         if (off >= GRD && !blanked(m_disp, slot)) begin
            e.an[slot] = 1'b0;
            e.seg      = glyph(m_disp[slot*4 +: 4]);
         end
      end
      exp_q.push_back(e);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compared += 4;
            if (an_n !== e.an) begin
               mismatched++;
               $display("FAIL an_n cycle %0d: got %b, want %b", cyc, an_n, e.an);
            end
            if (seg_n !== e.seg) begin
               mismatched++;
               $display("FAIL seg_n cycle %0d: got %h, want %h", cyc, seg_n, e.seg);
            end
            if (frame_start !== e.fs) begin
               mismatched++;
               $display("FAIL frame_start cycle %0d: got %b, want %b", cyc, frame_start, e.fs);
            end
            if (bcd_ready !== e.rdy) begin
               mismatched++;
               $display("FAIL bcd_ready cycle %0d: got %b, want %b", cyc, bcd_ready, e.rdy);
            end
         end
      end
   end

   // Offer a word and hold it until the handshake completes (bounded)
   task automatic send(input logic [4*N-1:0] w);
      bit rdy;
      bit done;
      bcd_valid = 1'b1;
      bcd_data  = w;
      done      = 1'b0;
      for (int n = 0; n < 4 * FRAME && !done; n++) begin
         rdy = bcd_ready;
         @(negedge clk);
         done = rdy;
      end
      compared++;
      if (!done) begin
         mismatched++;
         $display("FAIL send_timeout word %h: got no accept, want accept within %0d cycles", w, 4 * FRAME);
      end
      bcd_valid = 1'b0;
   endtask

   task automatic wait_an(input logic [N-1:0] target);
      bit hit;
      hit = 1'b0;
      for (int n = 0; n < 4 * FRAME && !hit; n++) begin
         @(negedge clk);
         hit = (an_n === target);
      end
      compared++;
      if (!hit) begin
         mismatched++;
         $display("FAIL wait_an: got %b, want %b within %0d cycles", an_n, target, 4 * FRAME);
      end
   endtask

   task automatic wait_frame();
      bit hit;
      hit = 1'b0;
      for (int n = 0; n < 4 * FRAME && !hit; n++) begin
         @(negedge clk);
         hit = (frame_start === 1'b1);
      end
      compared++;
      if (!hit) begin
         mismatched++;
         $display("FAIL wait_frame: got no frame_start, want one within %0d cycles", 4 * FRAME);
      end
   endtask

   initial begin
      logic [4*N-1:0] w;
      rst_n     = 1'b0;
      bcd_valid = 1'b0;
      bcd_data  = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);

      send(8'h42);
      repeat (2 * FRAME + 3) @(negedge clk);

      wait_an(2'b10);
      send(8'h13);
      send(8'h57);
      repeat (3 * FRAME) @(negedge clk);

      send(8'h0A);
      repeat (3 * FRAME) @(negedge clk);

      send(8'h00);
      repeat (3 * FRAME) @(negedge clk);

      // Reset while digit 0 is driven and a word is still pending
      wait_frame();
      send(8'h99);
      wait_an(2'b10);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      for (int n = 0; n < 500; n++) begin
         rst_n     = ($urandom_range(0, 249) != 0);
         bcd_valid = ($urandom_range(0, 5) == 0);
         for (int d = 0; d < N; d++)
            w[d*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         bcd_data = w;
         @(negedge clk);
      end
      rst_n     = 1'b1;
      bcd_valid = 1'b0;
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
